// File: rtl/map_port_arbiter_pkg.sv
// map_port_arbiter_pkg: shared sizes, requester ids and read tag for the map port arbiter
package map_port_arbiter_pkg;
  localparam int COORD_W = 6;
  localparam int N_REQ = 4;
  localparam int IDX_W = $clog2(N_REQ);
  localparam int REQ_TANK1 = 0;
  localparam int REQ_TANK2 = 1;
  localparam int REQ_SHELL1 = 2;
  localparam int REQ_SHELL2 = 3;
  typedef struct packed {
    logic valid;
    logic is_vga;
    logic [IDX_W-1:0] idx;
  } tag_t;
endpackage

// File: rtl/map_port_arbiter_rr_picker.sv
// map_port_arbiter_rr_picker: round-robin select of the first request at or after ptr
module map_port_arbiter_rr_picker
  import map_port_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] next_ptr
);
  logic [IDX_W-1:0] k;
  // scan downward so the candidate closest to ptr is the last one kept
  always_comb begin
    idx = '0;
    k = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = IDX_W'((int'(ptr) + i) % N_REQ);
      idx = req[k] ? k : idx;
    end
  end
  assign gnt = N_REQ'(|req) << idx;
  assign next_ptr = IDX_W'((int'(idx) + 1) % N_REQ);
endmodule

// File: rtl/map_port_arbiter.sv
// map_port_arbiter: shares the wall map read port between VGA (priority) and round-robin game requesters
module map_port_arbiter
  import map_port_arbiter_pkg::*;
#(
  parameter int MAP_LAT = 1,
  parameter int STARVE_MAX = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_vga_req,
  input  logic [COORD_W-1:0]       i_vga_x,
  input  logic [COORD_W-1:0]       i_vga_y,
  output logic                     o_vga_valid,
  output logic                     o_vga_is_wall,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*COORD_W-1:0] i_req_x,
  input  logic [N_REQ*COORD_W-1:0] i_req_y,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [N_REQ-1:0]         o_rsp_valid,
  output logic                     o_rsp_is_wall,
  output logic                     o_map_rd,
  output logic [COORD_W-1:0]       o_map_x,
  output logic [COORD_W-1:0]       o_map_y,
  input  logic                     i_map_is_wall,
  output logic                     o_starve
);
  localparam logic [9:0] STARVE_LIM = 10'(STARVE_MAX - 1);
  logic [IDX_W-1:0] ptr, idx, next_ptr;
  logic [N_REQ-1:0] pick;
  logic game_rd;
  tag_t tags [MAP_LAT];
  tag_t last;
  logic [9:0] wait_cnt [N_REQ];
  map_port_arbiter_rr_picker u_picker (
    .req(i_req),
    .ptr(ptr),
    .gnt(pick),
    .idx(idx),
    .next_ptr(next_ptr)
  );
  assign game_rd = !rst && !i_vga_req && |i_req;
  assign o_gnt = game_rd ? pick : '0;
  assign o_map_rd = !rst && (i_vga_req || |i_req);
  assign o_map_x = !o_map_rd ? '0 : i_vga_req ? i_vga_x : i_req_x[int'(idx)*COORD_W +: COORD_W];
  assign o_map_y = !o_map_rd ? '0 : i_vga_req ? i_vga_y : i_req_y[int'(idx)*COORD_W +: COORD_W];
  assign last = tags[MAP_LAT-1];
  assign o_vga_valid = last.valid && last.is_vga;
  assign o_rsp_valid = (last.valid && !last.is_vga) ? N_REQ'(1) << last.idx : '0;
  assign o_vga_is_wall = last.valid && i_map_is_wall;
  assign o_rsp_is_wall = o_vga_is_wall;
  // pointer moves past the granted requester; VGA and idle cycles leave it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else if (game_rd) ptr <= next_ptr;
  end
  // tag pipeline matches each map read to the requester that issued it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAP_LAT; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{valid: o_map_rd, is_vga: i_vga_req, idx: idx};
      for (int i = 1; i < MAP_LAT; i++) tags[i] <= tags[i-1];
    end
  end
  // saturating wait counters; the starve flag latches once any counter reaches the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_REQ; k++) wait_cnt[k] <= '0;
      o_starve <= 1'b0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (o_gnt[k]) wait_cnt[k] <= '0;
        else if (i_req[k] && wait_cnt[k] != '1) begin
          wait_cnt[k] <= wait_cnt[k] + 10'd1;
          if (wait_cnt[k] >= STARVE_LIM) o_starve <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_map_port_arbiter.sv
// tb_map_port_arbiter: directed table, corner sequences and random traffic against a queue-based model
module tb_map_port_arbiter;
  localparam int ST = 8;
  typedef struct {bit v; bit vga; int idx; bit wall;} rsp_t;
  typedef struct {bit vga; logic [5:0] vx; logic [5:0] vy; logic [3:0] req; logic [3:0] gnt;} vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic vga_req = 1'b0;
  logic [5:0] vga_x = '0, vga_y = '0;
  logic [3:0] req = '0;
  logic [5:0] rx [4];
  logic [5:0] ry [4];
  logic [23:0] req_x, req_y;
  logic vv1, vw1, rw1, rd1, st1, vv3, vw3, rw3, rd3, st3;
  logic [3:0] g1, g3, rv1, rv3;
  logic [5:0] mx1, my1, mx3, my3;
  logic m1, m3a, m3b, m3c;
  bit wall [64][64];
  int total = 0, bad = 0;
  int ptr_m, gk;
  int w_m [4];
  bit st_m;
  logic [3:0] e_g, last_eg, g1_s;
  logic e_rd, vv_s, vw_s;
  logic [5:0] e_x, e_y;
  rsp_t q1[$], q3[$];
  vec_t tbl[$];
  assign req_x = {rx[3], rx[2], rx[1], rx[0]};
  assign req_y = {ry[3], ry[2], ry[1], ry[0]};
  always #5 clk = ~clk;
  map_port_arbiter #(.MAP_LAT(1), .STARVE_MAX(ST)) u1 (
    .clk(clk), .rst(rst), .i_vga_req(vga_req), .i_vga_x(vga_x), .i_vga_y(vga_y),
    .o_vga_valid(vv1), .o_vga_is_wall(vw1), .i_req(req), .i_req_x(req_x), .i_req_y(req_y),
    .o_gnt(g1), .o_rsp_valid(rv1), .o_rsp_is_wall(rw1), .o_map_rd(rd1), .o_map_x(mx1),
    .o_map_y(my1), .i_map_is_wall(m1), .o_starve(st1));
  map_port_arbiter #(.MAP_LAT(3), .STARVE_MAX(ST)) u3 (
    .clk(clk), .rst(rst), .i_vga_req(vga_req), .i_vga_x(vga_x), .i_vga_y(vga_y),
    .o_vga_valid(vv3), .o_vga_is_wall(vw3), .i_req(req), .i_req_x(req_x), .i_req_y(req_y),
    .o_gnt(g3), .o_rsp_valid(rv3), .o_rsp_is_wall(rw3), .o_map_rd(rd3), .o_map_x(mx3),
    .o_map_y(my3), .i_map_is_wall(m3c), .o_starve(st3));
  // map store models; junk data when no read so invalid tags must be masked
  always @(posedge clk) begin
    m1 <= rd1 ? wall[my1][mx1] : 1'($urandom);
    m3a <= rd3 ? wall[my3][mx3] : 1'($urandom);
    m3b <= m3a;
    m3c <= m3b;
  end
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask
  task automatic chk_dut(string s, rsp_t r, logic [3:0] g, logic rd, logic [5:0] mx, logic [5:0] my,
                         logic vv, logic vw, logic [3:0] rv, logic rw, logic st);
    chk({s, "_gnt"}, 32'(g), 32'(e_g));
    chk({s, "_map_rd"}, 32'(rd), 32'(e_rd));
    chk({s, "_map_x"}, 32'(mx), 32'(e_x));
    chk({s, "_map_y"}, 32'(my), 32'(e_y));
    chk({s, "_vga_valid"}, 32'(vv), 32'(r.v && r.vga));
    chk({s, "_vga_wall"}, 32'(vw), 32'(r.v && r.wall));
    chk({s, "_rsp_valid"}, 32'(rv), (r.v && !r.vga) ? 32'(1) << r.idx : 32'(0));
    chk({s, "_rsp_wall"}, 32'(rw), 32'(r.v && r.wall));
    chk({s, "_starve"}, 32'(st), 32'(st_m));
  endtask
  task automatic model_reset();
    rsp_t inv;
    inv = '{0, 0, 0, 0};
    q1.delete();
    q3.delete();
    q1.push_back(inv);
    repeat (3) q3.push_back(inv);
    ptr_m = 0;
    for (int k = 0; k < 4; k++) w_m[k] = 0;
    st_m = 0;
  endtask
  task automatic cycle();
    rsp_t r1, r3, nr;
    @(negedge clk);
    if (rst) model_reset();
    e_g = '0; e_rd = 0; e_x = '0; e_y = '0; gk = 0;
    if (!rst && vga_req) begin
      e_rd = 1; e_x = vga_x; e_y = vga_y;
    end else if (!rst && req != 0) begin
      for (int i = 3; i >= 0; i--) if (((req >> ((ptr_m + i) % 4)) & 4'b1) != 0) gk = (ptr_m + i) % 4;
      e_rd = 1; e_g = 4'b1 << gk; e_x = rx[gk]; e_y = ry[gk];
    end
    r1 = q1.pop_front();
    r3 = q3.pop_front();
    g1_s = g1; vv_s = vv1; vw_s = vw1;
    chk_dut("L1", r1, g1, rd1, mx1, my1, vv1, vw1, rv1, rw1, st1);
    chk_dut("L3", r3, g3, rd3, mx3, my3, vv3, vw3, rv3, rw3, st3);
    nr = '{e_rd, vga_req, gk, wall[e_y][e_x]};
    q1.push_back(nr);
    q3.push_back(nr);
    if (!rst) begin
      if (e_g != 0) ptr_m = (gk + 1) % 4;
      for (int k = 0; k < 4; k++) begin
        if (e_g[2'(k)]) w_m[k] = 0;
        else if (req[2'(k)] && w_m[k] < 1023) w_m[k]++;
        if (w_m[k] >= ST) st_m = 1;
      end
    end
    last_eg = e_g;
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int y = 0; y < 64; y++) for (int x = 0; x < 64; x++) wall[y][x] = 1'($urandom);
    wall[7][5] = 1;
    wall[7][6] = 0;
    for (int k = 0; k < 4; k++) begin rx[k] = 6'(10 + k); ry[k] = 6'(20 + 3 * k); end
    tbl.push_back('{0, 0, 0, 4'b1111, 4'b0001});
    tbl.push_back('{0, 0, 0, 4'b1111, 4'b0010});
    tbl.push_back('{0, 0, 0, 4'b1111, 4'b0100});
    tbl.push_back('{0, 0, 0, 4'b1111, 4'b1000});
    tbl.push_back('{0, 0, 0, 4'b1111, 4'b0001});
    tbl.push_back('{0, 0, 0, 4'b0010, 4'b0010});
    tbl.push_back('{0, 0, 0, 4'b0011, 4'b0001});
    tbl.push_back('{0, 0, 0, 4'b0000, 4'b0000});
    for (int i = 0; i < 10; i++) tbl.push_back('{1, 6'(i + 1), 6'(2 * i), 4'b0100, 4'b0000});
    tbl.push_back('{0, 0, 0, 4'b0100, 4'b0100});
    tbl.push_back('{0, 0, 0, 4'b0000, 4'b0000});
    repeat (2) cycle();
    chk("reset_starve", 32'(st1), 0);
    rst = 0;
    foreach (tbl[i]) begin
      vga_req = tbl[i].vga; vga_x = tbl[i].vx; vga_y = tbl[i].vy; req = tbl[i].req;
      cycle();
      chk($sformatf("tbl%0d_gnt", i), 32'(g1_s), 32'(tbl[i].gnt));
    end
    vga_req = 1; vga_x = 5; vga_y = 7; req = 0;
    cycle();
    vga_x = 6;
    cycle();
    chk("wall_5_7", 32'(vw_s), 1);
    vga_req = 0;
    cycle();
    chk("wall_6_7_valid", 32'(vv_s), 1);
    chk("wall_6_7", 32'(vw_s), 0);
    req = 4'b1111;
    repeat (2) cycle();
    rst = 1;
    cycle();
    rst = 0; req = 0;
    repeat (4) cycle();
    req = 4'b0110;
    cycle();
    chk("rst_first_gnt", 32'(g1_s), 32'(4'b0010));
    req = 0;
    rst = 1;
    cycle();
    rst = 0; vga_req = 1; vga_x = 1; vga_y = 2; req = 4'b0010;
    repeat (ST) cycle();
    vga_req = 0;
    cycle();
    chk("starve_set", 32'(st1), 1);
    chk("starve_gnt", 32'(g1_s), 32'(4'b0010));
    req = 0;
    repeat (2) cycle();
    chk("starve_sticky", 32'(st3), 1);
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom % 150) == 0;
      vga_req = ($urandom % 4) == 0;
      vga_x = 6'($urandom); vga_y = 6'($urandom);
      for (int k = 0; k < 4; k++) if (!(req[2'(k)] && !last_eg[2'(k)])) begin
        req[2'(k)] = ($urandom % 3) == 0;
        rx[k] = 6'($urandom); ry[k] = 6'($urandom);
      end
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
